pic_init_ctrl: RTL and testbench
================================

# pic_init_ctrl

Write-sequencing controller for the 8259A-compatible PIC. It decodes CPU register writes into the ICW1–ICW4 initialization sequence and OCW1–OCW3 operational commands. It drives `cur_MASK`/`MASK_reset` into the IMR and holds the configuration fields that the priority resolver, cascade and INTA logic consume. It sits between the bus/data-buffer interface and the IMR, ISR/IRR and cascade blocks.

## Interface
- No parameters.
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: one-cycle write strobe from the bus interface, already synchronized to `clk`.
- `a0` in 1: register address bit.
- `din` in 8: write data.
- `cur_MASK` out 8: mask value to the IMR.
- `MASK_reset` out 1: one-cycle IMR clear pulse.
- `init_done` out 1: init sequence complete; OCWs accepted.
- `ltim` out 1: level-triggered mode (ICW1 D3).
- `single` out 1: single mode (ICW1 D1).
- `vector_base` out 5: T7–T3 (ICW2 D7:D3).
- `cascade_cfg` out 8: ICW3 byte.
- `upm` out 1: ICW4 D0.
- `aeoi` out 1: ICW4 D1.
- `ms` out 1: ICW4 D2.
- `buf_mode` out 1: ICW4 D3.
- `sfnm` out 1: ICW4 D4.
- `ocw2_strobe` out 1: one-cycle pulse on OCW2 accept.
- `ocw2_cmd` out 3: OCW2 D7:D5 (R, SL, EOI).
- `ocw2_level` out 3: OCW2 D2:D0.
- `smm` out 1: special mask mode.
- `ris` out 1: read-register select (0 = IRR, 1 = ISR).
- `poll_req` out 1: one-cycle pulse on OCW3 with P=1.

## Operation
- States: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY. Reset → IDLE.
- Writes are only considered on cycles with `wr_en`=1.
- **ICW1** (`a0`=0, `din[4]`=1): accepted in ANY state, including mid-sequence, and restarts init. On accept:
  - Latch `ltim`, `single`, and internal `ic4`=D0.
  - Clear `upm`/`aeoi`/`ms`/`buf_mode`/`sfnm`, `smm`, `ris`, and `cascade_cfg`.
  - Clear `cur_MASK` to 0; pulse `MASK_reset`; drop `init_done`.
  - Go to WAIT_ICW2.
- **WAIT_ICW2**, `a0`=1: latch `vector_base`=`din[7:3]`. Next state:
  - WAIT_ICW3 if `single`=0;
  - else WAIT_ICW4 if `ic4`=1;
  - else READY.
- **WAIT_ICW3**, `a0`=1: latch `cascade_cfg`=`din`. Go to WAIT_ICW4 if `ic4`, else READY.
- **WAIT_ICW4**, `a0`=1: latch ICW4 D4:D0 into `sfnm`, `buf_mode`, `ms`, `aeoi`, `upm`. Go to READY.
- Entering READY sets `init_done`=1.
- In WAIT_* states, `a0`=0 writes with D4=0 are ignored; state is unchanged.
- In IDLE, all writes except ICW1 are ignored.
- **READY:**
  - `a0`=1 → OCW1: `cur_MASK`=`din`. No `MASK_reset`.
  - `a0`=0, D4=0, D3=0 → OCW2: `ocw2_cmd`=`din[7:5]`, `ocw2_level`=`din[2:0]`, pulse `ocw2_strobe`.
  - `a0`=0, D4=0, D3=1 → OCW3:
    - If D6 (ESMM)=1, then `smm`=D5; otherwise `smm` is held.
    - If D1 (RR)=1, then `ris`=D0; otherwise `ris` is held.
    - If D2=1, pulse `poll_req`.
- `ocw2_cmd`/`ocw2_level` hold their last value between strobes.

## Timing
- Reset: state IDLE; every output 0, including `cur_MASK`=0x00 and `MASK_reset`=0.
- All outputs are registered. A write sampled at edge N is visible after edge N, i.e. 1-cycle latency.
- `MASK_reset`, `ocw2_strobe` and `poll_req` are high for exactly one cycle per accepted write. Back-to-back writes give back-to-back pulses.
- `cur_MASK` reads 0x00 in the same cycle that `MASK_reset`=1.
- `reset` together with `wr_en`: reset wins and the write is discarded.
- ICW1 with `wr_en` held for consecutive cycles: each cycle is a fresh ICW1 (restart, new pulse).
- `init_done` falls in the cycle after ICW1 and rises in the cycle after the final ICW.

## Test plan
- Reset, then ICW1=0x13 (`a0`=0), ICW2=0x20 (`a0`=1), ICW4=0x03 (`a0`=1) → `single`=1, `vector_base`=0x04, `upm`=1, `aeoi`=1, `init_done`=1 after the 3rd write; `MASK_reset` pulses once, in the cycle after ICW1.
- Cascade init: ICW1=0x11, ICW2=0x40, ICW3=0x04, ICW4=0x1D → `cascade_cfg`=0x04, `sfnm`=1, `buf_mode`=1, `ms`=1, `upm`=1; then OCW1=0xF0 → `cur_MASK`=0xF0 one cycle later.
- READY with `cur_MASK`=0x0F; ICW1=0x12 → `cur_MASK`=0x00, `MASK_reset`=1 for one cycle, `init_done`=0; ICW2 → READY (`single`=1, `ic4`=0).
- Restart mid-sequence: ICW1=0x11, ICW2, then ICW1=0x13 before ICW3 → state WAIT_ICW2; the next `a0`=1 write is taken as ICW2, not ICW3.
- OCW2=0x65 → `ocw2_strobe` one cycle, `ocw2_cmd`=3'b011, `ocw2_level`=5. OCW3=0x6B → `smm`=1, `ris`=1. OCW3=0x0C → `poll_req` one cycle; `smm` and `ris` unchanged.
- IDLE after reset: `a0`=1 write of 0xFF and OCW2 → no output changes. `reset` asserted with an ICW1 write in the same cycle → IDLE, no `MASK_reset` pulse.

Source files
------------

// File: rtl/pic_init_ctrl.sv
// pic_init_ctrl
// Write-sequencing controller for an 8259A-compatible PIC. It decodes CPU
// register writes into the ICW1..ICW4 initialization sequence and the
// OCW1..OCW3 operational commands. It also holds the configuration fields
// that the IMR, priority resolver, cascade and INTA logic consume.
//
// Ports
//   clk, reset      : clock; synchronous active-high reset
//   wr_en, a0, din  : one-cycle write strobe, register address bit, write data
//   cur_MASK        : IMR mask value
//   MASK_reset      : one-cycle IMR clear pulse
//   init_done       : init sequence complete, so OCWs are accepted
//   ltim, single    : ICW1 D3, D1
//   vector_base     : ICW2 D7:D3
//   cascade_cfg     : ICW3 byte
//   upm/aeoi/ms/buf_mode/sfnm : ICW4 D0..D4
//   ocw2_strobe/cmd/level     : OCW2 accept pulse, D7:D5, D2:D0
//   smm, ris        : special mask mode, read-register select
//   poll_req        : one-cycle pulse on OCW3 with the poll bit set
module pic_init_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [7:0] cur_MASK,
  output logic       MASK_reset,
  output logic       init_done,
  output logic       ltim,
  output logic       single,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic       upm,
  output logic       aeoi,
  output logic       ms,
  output logic       buf_mode,
  output logic       sfnm,
  output logic       ocw2_strobe,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       smm,
  output logic       ris,
  output logic       poll_req
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_ICW2 = 3'd1;
  localparam logic [2:0] WAIT_ICW3 = 3'd2;
  localparam logic [2:0] WAIT_ICW4 = 3'd3;
  localparam logic [2:0] READY     = 3'd4;

  logic [2:0] state;
  logic       ic4;
  logic       icw1_wr;

  // ICW1 is recognised in every state, so decode it ahead of the FSM.
  assign icw1_wr = wr_en & ~a0 & din[4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ic4         <= 1'b0;
      cur_MASK    <= 8'h00;
      MASK_reset  <= 1'b0;
      init_done   <= 1'b0;
      ltim        <= 1'b0;
      single      <= 1'b0;
      vector_base <= 5'd0;
      cascade_cfg <= 8'h00;
      upm         <= 1'b0;
      aeoi        <= 1'b0;
      ms          <= 1'b0;
      buf_mode    <= 1'b0;
      sfnm        <= 1'b0;
      ocw2_strobe <= 1'b0;
      ocw2_cmd    <= 3'd0;
      ocw2_level  <= 3'd0;
      smm         <= 1'b0;
      ris         <= 1'b0;
      poll_req    <= 1'b0;
    end else begin
      // Pulses last a single cycle unless re-armed by this cycle's write.
      MASK_reset  <= 1'b0;
      ocw2_strobe <= 1'b0;
      poll_req    <= 1'b0;

      if (icw1_wr) begin
        // ICW1 restarts initialization from any state.
        ltim        <= din[3];
        single      <= din[1];
        ic4         <= din[0];
        upm         <= 1'b0;
        aeoi        <= 1'b0;
        ms          <= 1'b0;
        buf_mode    <= 1'b0;
        sfnm        <= 1'b0;
        smm         <= 1'b0;
        ris         <= 1'b0;
        cascade_cfg <= 8'h00;
        cur_MASK    <= 8'h00;
        MASK_reset  <= 1'b1;
        init_done   <= 1'b0;
        state       <= WAIT_ICW2;
      end else if (wr_en) begin
        case (state)
          WAIT_ICW2: if (a0) begin
            vector_base <= din[7:3];
            // The single flag was latched by ICW1 and already holds its final value.
            if (!single)  state <= WAIT_ICW3;
            else if (ic4) state <= WAIT_ICW4;
            else begin
              state     <= READY;
              init_done <= 1'b1;
            end
          end
          WAIT_ICW3: if (a0) begin
            cascade_cfg <= din;
            if (ic4) state <= WAIT_ICW4;
            else begin
              state     <= READY;
              init_done <= 1'b1;
            end
          end
          WAIT_ICW4: if (a0) begin
            sfnm      <= din[4];
            buf_mode  <= din[3];
            ms        <= din[2];
            aeoi      <= din[1];
            upm       <= din[0];
            state     <= READY;
            init_done <= 1'b1;
          end
          READY: begin
            if (a0) begin
              cur_MASK <= din;
            end else if (!din[3]) begin
              ocw2_cmd    <= din[7:5];
              ocw2_level  <= din[2:0];
              ocw2_strobe <= 1'b1;
            end else begin
              if (din[6]) smm <= din[5];
              if (din[1]) ris <= din[0];
              poll_req <= din[2];
            end
          end
          default: ; // IDLE ignores everything except ICW1
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pic_init_ctrl.sv
// Scoreboard bench for pic_init_ctrl. A driver applies one write per cycle.
// For each write, a reference model computes the full expected output word
// and pushes it into a queue. A monitor, sampling after each rising edge,
// pops one entry per cycle and compares it with the DUT outputs.
module tb_pic_init_ctrl;
  logic       clk = 1'b0;
  logic       reset, wr_en, a0;
  logic [7:0] din;
  logic [7:0] cur_MASK, cascade_cfg;
  logic       MASK_reset, init_done, ltim, single, upm, aeoi, ms, buf_mode, sfnm;
  logic [4:0] vector_base;
  logic       ocw2_strobe, smm, ris, poll_req;
  logic [2:0] ocw2_cmd, ocw2_level;

  always #5 clk = ~clk;

  pic_init_ctrl dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .a0(a0), .din(din),
    .cur_MASK(cur_MASK), .MASK_reset(MASK_reset), .init_done(init_done),
    .ltim(ltim), .single(single), .vector_base(vector_base),
    .cascade_cfg(cascade_cfg), .upm(upm), .aeoi(aeoi), .ms(ms),
    .buf_mode(buf_mode), .sfnm(sfnm), .ocw2_strobe(ocw2_strobe),
    .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level), .smm(smm), .ris(ris),
    .poll_req(poll_req)
  );

  // Layout of the 40-bit output word, used for both expected and actual values.
  logic [39:0] act;
  assign act = {cur_MASK, MASK_reset, init_done, ltim, single, vector_base,
                cascade_cfg, upm, aeoi, ms, buf_mode, sfnm,
                ocw2_strobe, ocw2_cmd, ocw2_level, smm, ris, poll_req};

  logic [39:0] sb[$];
  int tests = 0;
  int fails = 0;

  // Reference model state. pend holds the ICW numbers still owed.
  int         pend[$];
  logic [7:0] m_mask, m_casc;
  logic       m_mrst, m_done, m_ltim, m_single, m_ic4;
  logic [4:0] m_vb, m_icw4;
  logic       m_stb, m_smm, m_ris, m_poll;
  logic [2:0] m_cmd, m_lvl;

  task automatic model(input logic r, input logic w, input logic a, input logic [7:0] d);
    int k;
    if (r) begin
      pend.delete();
      m_mask = 0; m_casc = 0; m_mrst = 0; m_done = 0; m_ltim = 0; m_single = 0;
      m_ic4 = 0; m_vb = 0; m_icw4 = 0; m_stb = 0; m_smm = 0; m_ris = 0;
      m_poll = 0; m_cmd = 0; m_lvl = 0;
      return;
    end
    m_mrst = 0; m_stb = 0; m_poll = 0;
    if (!w) return;
    if (!a && d[4]) begin
      m_ltim = d[3]; m_single = d[1]; m_ic4 = d[0];
      m_icw4 = 0; m_smm = 0; m_ris = 0; m_casc = 0; m_mask = 0;
      m_mrst = 1; m_done = 0;
      pend.delete();
      pend.push_back(2);
      if (!m_single) pend.push_back(3);
      if (m_ic4) pend.push_back(4);
    end else if (pend.size() != 0) begin
      if (a) begin
        k = pend.pop_front();
        if (k == 2) m_vb = d[7:3];
        else if (k == 3) m_casc = d;
        else m_icw4 = d[4:0];
        if (pend.size() == 0) m_done = 1;
      end
    end else if (m_done) begin
      if (a) m_mask = d;
      else if (!d[3]) begin m_cmd = d[7:5]; m_lvl = d[2:0]; m_stb = 1; end
      else begin
        if (d[6]) m_smm = d[5];
        if (d[1]) m_ris = d[0];
        m_poll = d[2];
      end
    end
  endtask

  // Drive one cycle of stimulus and queue the expected post-edge outputs.
  task automatic step(input logic r, input logic w, input logic a, input logic [7:0] d);
    @(negedge clk);
    reset = r; wr_en = w; a0 = a; din = d;
    model(r, w, a, d);
    sb.push_back({m_mask, m_mrst, m_done, m_ltim, m_single, m_vb, m_casc,
                  m_icw4[0], m_icw4[1], m_icw4[2], m_icw4[3], m_icw4[4],
                  m_stb, m_cmd, m_lvl, m_smm, m_ris, m_poll});
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    step(1'b0, 1'b1, a, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output word.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      logic [39:0] e;
      e = sb.pop_front();
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL outputs t=%0t got=%h exp=%h", $time, act, e);
      end
    end
  end

  initial begin
    reset = 1; wr_en = 0; a0 = 0; din = 0;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    // Writes in IDLE are ignored; reset discards a coincident ICW1.
    wr(1'b1, 8'hFF); wr(1'b0, 8'h65); wr(1'b0, 8'h6B);
    step(1'b1, 1'b1, 1'b0, 8'h13);
    idle();
    // Single mode with ICW4.
    wr(1'b0, 8'h13); wr(1'b1, 8'h20); wr(1'b1, 8'h03); idle();
    // Cascade init followed by OCW1.
    wr(1'b0, 8'h11); wr(1'b1, 8'h40); wr(1'b0, 8'h05); wr(1'b1, 8'h04);
    wr(1'b1, 8'h1D); wr(1'b1, 8'hF0); idle();
    // ICW1 from READY clears the mask; single mode without ICW4.
    wr(1'b1, 8'h0F); wr(1'b0, 8'h12); idle(); wr(1'b1, 8'h88); idle();
    // Restart in the middle of the sequence.
    wr(1'b0, 8'h11); wr(1'b1, 8'h48); wr(1'b0, 8'h13); wr(1'b1, 8'h50);
    wr(1'b1, 8'h01); idle();
    // OCW2 and OCW3, back-to-back pulses.
    wr(1'b0, 8'h65); wr(1'b0, 8'h20); wr(1'b0, 8'h6B); wr(1'b0, 8'h0C);
    wr(1'b0, 8'h0C); wr(1'b0, 8'h4A); idle();
    // ICW1 with wr_en held across consecutive cycles.
    wr(1'b0, 8'h1B); wr(1'b0, 8'h1B); wr(1'b0, 8'h13); idle();
    // Randomized stimulus.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d[4] = 1'b1;
      else if ($urandom_range(0, 1) == 0) d[4] = 1'b0;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), d);
    end
    idle();
    @(posedge clk); #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
